// File: rtl/uart_debug_bridge_if.sv
// uart_debug_bridge_if: memory debug port between the UART bridge and debug_amif.
//   master (bridge side): drives dbg_read, dbg_write, dbg_addr, dbg_store;
//                         receives dbg_load, dbg_ready.
//   slave (controller side): the mirror image.
interface uart_debug_bridge_if;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_store;
  logic [31:0] dbg_load;
  logic        dbg_ready;

  modport master (
    output dbg_read, dbg_write, dbg_addr, dbg_store,
    input  dbg_load, dbg_ready
  );

  modport slave (
    input  dbg_read, dbg_write, dbg_addr, dbg_store,
    output dbg_load, dbg_ready
  );
endinterface

// File: rtl/uart_debug_bridge.sv
// uart_debug_bridge: host-driven peek/poke of memory-mapped words over an 8N1 UART.
//   Frames (big-endian): 0x52 A3..A0 -> D3..D0 ; 0x57 A3..A0 D3..D0 -> 0x4B ;
//   unknown command or unaligned address -> 0x3F.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   rxd        UART receive line (asynchronous, idle high)
//   txd        UART transmit line (idle high)
//   dbg        debug port, master side (read/write/addr/store out, load/ready in)
//   dbg_done   one-cycle pulse when the last response stop bit has completed
//   busy       high whenever the command FSM is not idle
// Build option: define DEBUG_BRIDGE_TIMEOUT_EN to drop partial frames after
// TIMEOUT_CYCLES of inter-byte silence.
module uart_debug_bridge #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  output logic                txd,
  uart_debug_bridge_if.master dbg,
  output logic                dbg_done,
  output logic                busy
);
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] REPLY_OK  = 8'h4B;
  localparam logic [7:0] REPLY_ERR = 8'h3F;

  if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("uart_debug_bridge: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP} state_t;

  // ---------------- receiver ----------------
  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic [7:0]    rx_byte;

  // Synchronise rxd, find the start edge, sample each bit at its centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_meta  <= rxd;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // a glitch shorter than half a bit is not a start bit
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // framing errors are dropped silently
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- command FSM + transmitter ----------------
  state_t        state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_sh;
  logic [23:0]   data_sh;
  logic [31:0]   resp;
  logic [2:0]    resp_left;
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_frame;
  logic          tx_end_c;
  logic          tx_load_c;
  logic          to_expired_c;

  // Next response byte loads at RESP entry or exactly as the previous stop bit ends.
  assign tx_end_c  = tx_busy && (tx_cnt == CW'(CLKS_PER_BIT - 1)) && (tx_bit == 4'd9);
  assign tx_load_c = (state == ST_RESP) && (resp_left != 3'd0) && (!tx_busy || tx_end_c);

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Inter-byte watchdog for partially received frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (rx_valid) begin
      to_cnt <= TW'(TIMEOUT_CYCLES);
    end else if ((state == ST_ADDR || state == ST_DATA) && to_cnt != '0) begin
      to_cnt <= to_cnt - TW'(1);
    end
  end

  assign to_expired_c = (state == ST_ADDR || state == ST_DATA) && (to_cnt == '0);
`else
  assign to_expired_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      is_write      <= 1'b0;
      byte_cnt      <= '0;
      addr_sh       <= '0;
      data_sh       <= '0;
      resp          <= '0;
      resp_left     <= '0;
      dbg.dbg_read  <= 1'b0;
      dbg.dbg_write <= 1'b0;
      dbg.dbg_addr  <= '0;
      dbg.dbg_store <= '0;
      dbg_done      <= 1'b0;
      txd           <= 1'b1;
      tx_busy       <= 1'b0;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_frame      <= '1;
    end else begin
      dbg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            busy     <= 1'b1;
            if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
              is_write <= (rx_byte == CMD_WRITE);
              state    <= ST_ADDR;
            end else begin
              resp      <= {REPLY_ERR, 24'h0};
              resp_left <= 3'd1;
              state     <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            addr_sh  <= {addr_sh[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= ST_DATA;
              end else if (rx_byte[1:0] != 2'b00) begin
                resp      <= {REPLY_ERR, 24'h0};
                resp_left <= 3'd1;
                state     <= ST_RESP;
              end else begin
                dbg.dbg_addr <= {addr_sh[23:0], rx_byte};
                dbg.dbg_read <= 1'b1;
                state        <= ST_BUS;
              end
            end
          end else if (to_expired_c) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            data_sh  <= {data_sh[15:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (addr_sh[1:0] != 2'b00) begin
                resp      <= {REPLY_ERR, 24'h0};
                resp_left <= 3'd1;
                state     <= ST_RESP;
              end else begin
                dbg.dbg_addr  <= addr_sh;
                dbg.dbg_store <= {data_sh, rx_byte};
                dbg.dbg_write <= 1'b1;
                state         <= ST_BUS;
              end
            end
          end else if (to_expired_c) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_BUS: begin
          if (dbg.dbg_ready) begin
            dbg.dbg_read  <= 1'b0;
            dbg.dbg_write <= 1'b0;
            resp          <= is_write ? {REPLY_OK, 24'h0} : dbg.dbg_load;
            resp_left     <= is_write ? 3'd1 : 3'd4;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_load_c) begin
            txd       <= 1'b0;
            tx_frame  <= {1'b1, resp[31:24]};
            resp      <= {resp[23:0], 8'h00};
            resp_left <= resp_left - 3'd1;
            tx_busy   <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
          end else if (tx_busy) begin
            if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
              tx_cnt <= '0;
              if (tx_bit == 4'd9) begin
                tx_busy  <= 1'b0;
                dbg_done <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                tx_bit   <= tx_bit + 4'd1;
                txd      <= tx_frame[0];
                tx_frame <= {1'b1, tx_frame[8:1]};
              end
            end else begin
              tx_cnt <= tx_cnt + CW'(1);
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
